// File: rtl/xiphy_pll_seq_if.sv
// Control/status bundle between the XiPHY PLL bring-up sequencer and its requester.
// The master side drives start and the raw lock inputs. The slave side is the sequencer.
interface xiphy_pll_seq_if #(
    parameter int unsigned MAX_RETRY = 3
);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic          start;
    logic          mmcm_lock;
    logic          pll_lock;
    logic          pll_rst;
    logic          pll_gate;
    logic          phy_ready;
    logic          lock_lost;
    logic          fail;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    modport master (
        output start, mmcm_lock, pll_lock,
        input  pll_rst, pll_gate, phy_ready, lock_lost, fail, retry_cnt, state
    );

    modport slave (
        input  start, mmcm_lock, pll_lock,
        output pll_rst, pll_gate, phy_ready, lock_lost, fail, retry_cnt, state
    );
endinterface

// File: rtl/xiphy_pll_seq.sv
// XiPHY PLL bank bring-up and lock supervision sequencer (clk_div domain).
// Optional feature macro PLL_AUTO_RELOCK_EN: lock loss in READY relocks instead of failing.
module xiphy_pll_seq #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned GATE_DELAY   = 64,
    parameter int unsigned GATE_HOLD    = 8,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk_div,
    input  logic             rst_div_n,
    xiphy_pll_seq_if.slave   bus
);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(GATE_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(GATE_HOLD - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_MMCM = 3'd1,
        S_PLL_RST   = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_SETTLE    = 3'd4,
        S_GATE      = 3'd5,
        S_READY     = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    logic             r_mmcm_meta, r_mmcm_s;
    logic             r_pll_meta,  r_pll_s;
    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt,  w_cnt_inc;
    logic [RW-1:0]    r_retry,  w_retry_nxt;
    logic             r_pll_rst,   w_pll_rst_nxt;
    logic             r_pll_gate,  w_pll_gate_nxt;
    logic             r_phy_ready, w_phy_ready_nxt;
    logic             r_lock_lost, w_lock_lost_nxt;
    logic             r_fail,      w_fail_nxt;

    // Two-flop synchronizers for the asynchronous lock indicators
    always_ff @(posedge clk_div or negedge rst_div_n) begin
        if (!rst_div_n) begin
            r_mmcm_meta <= 1'b0;
            r_mmcm_s    <= 1'b0;
            r_pll_meta  <= 1'b0;
            r_pll_s     <= 1'b0;
        end else begin
            r_mmcm_meta <= bus.mmcm_lock;
            r_mmcm_s    <= r_mmcm_meta;
            r_pll_meta  <= bus.pll_lock;
            r_pll_s     <= r_pll_meta;
        end
    end

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state logic; the outer if/else chain encodes the transition priority
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_lock_lost_nxt = 1'b0;

        if (r_state != S_IDLE && !bus.start) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state inside {S_PLL_RST, S_WAIT_LOCK, S_SETTLE, S_GATE, S_READY}
                     && !r_mmcm_s) begin
            w_cnt_nxt = '0;
            if (r_state == S_READY) begin
                w_lock_lost_nxt = 1'b1;
`ifdef PLL_AUTO_RELOCK_EN
                w_state_nxt = S_WAIT_MMCM;
                w_retry_nxt = '0;
`else
                w_state_nxt = S_FAIL;
`endif
            end else begin
                w_state_nxt = S_WAIT_MMCM;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (bus.start) begin
                        w_state_nxt = S_WAIT_MMCM;
                        w_retry_nxt = '0;
                    end
                end
                S_WAIT_MMCM: begin
                    if (r_mmcm_s) begin
                        w_state_nxt = S_PLL_RST;
                        w_cnt_nxt   = '0;
                    end
                end
                S_PLL_RST: begin
                    if (r_cnt >= RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_pll_s) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= TIMEOUT_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_retry < RETRY_MAX) begin
                            w_retry_nxt = r_retry + RW'(1);
                            w_state_nxt = S_PLL_RST;
                        end else begin
                            w_state_nxt = S_FAIL;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_SETTLE: begin
                    if (!r_pll_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= SETTLE_LAST) begin
                        w_state_nxt = S_GATE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_GATE: begin
                    // A lock drop before READY is treated like a settle glitch
                    if (!r_pll_s) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= HOLD_LAST) begin
                        w_state_nxt = S_READY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_READY: begin
                    if (!r_pll_s) begin
                        w_lock_lost_nxt = 1'b1;
                        w_cnt_nxt       = '0;
`ifdef PLL_AUTO_RELOCK_EN
                        w_state_nxt = S_PLL_RST;
                        w_retry_nxt = '0;
`else
                        w_state_nxt = S_FAIL;
`endif
                    end
                end
                S_FAIL: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state so outputs change on the entry edge
    always_comb begin
        w_pll_rst_nxt   = 1'b1;
        w_pll_gate_nxt  = 1'b0;
        w_phy_ready_nxt = 1'b0;
        w_fail_nxt      = 1'b0;
        case (w_state_nxt)
            S_WAIT_LOCK, S_SETTLE: w_pll_rst_nxt = 1'b0;
            S_GATE: begin
                w_pll_rst_nxt  = 1'b0;
                w_pll_gate_nxt = 1'b1;
            end
            S_READY: begin
                w_pll_rst_nxt   = 1'b0;
                w_pll_gate_nxt  = 1'b1;
                w_phy_ready_nxt = 1'b1;
            end
            S_FAIL:  w_fail_nxt = 1'b1;
            default: w_pll_rst_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_div_n) begin
        if (!rst_div_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_pll_gate  <= 1'b0;
            r_phy_ready <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_pll_gate  <= w_pll_gate_nxt;
            r_phy_ready <= w_phy_ready_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.pll_gate  = r_pll_gate;
    assign bus.phy_ready = r_phy_ready;
    assign bus.lock_lost = r_lock_lost;
    assign bus.fail      = r_fail;
    assign bus.retry_cnt = r_retry;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_xiphy_pll_seq.sv
// Scoreboard bench for xiphy_pll_seq: expected state entries (outputs + dwell of the
// previous state) are queued by the stimulus and checked by a monitor on each state change.
module tb_xiphy_pll_seq;
    logic clk_div   = 1'b0;
    logic rst_div_n = 1'b0;

    always #5 clk_div = ~clk_div;

    xiphy_pll_seq_if #(.MAX_RETRY(2)) bus ();

    xiphy_pll_seq #(
        .CNT_W(16), .RST_CYCLES(4), .LOCK_TIMEOUT(20),
        .GATE_DELAY(8), .GATE_HOLD(2), .MAX_RETRY(2)
    ) dut (
        .clk_div  (clk_div),
        .rst_div_n(rst_div_n),
        .bus      (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       rst;
        logic       gate;
        logic       rdy;
        logic       ll;
        logic       fl;
        logic [1:0] rc;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dwell;   // cycles spent in the previous state; 0 = not checked
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic snap_t mk(input int st, input int rc, input bit ll);
        snap_t s;
        s.st   = 3'(st);
        s.rst  = (st == 0 || st == 1 || st == 2 || st == 7);
        s.gate = (st == 5 || st == 6);
        s.rdy  = (st == 6);
        s.ll   = ll;
        s.fl   = (st == 7);
        s.rc   = 2'(rc);
        return s;
    endfunction

    task automatic push(input int st, input int rc, input bit ll, input int dwell);
        exp_t e;
        e.s     = mk(st, rc, ll);
        e.dwell = dwell;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_div);
    endtask

    task automatic drive(input bit s, input bit m, input bit p);
        bus.start     = s;
        bus.mmcm_lock = m;
        bus.pll_lock  = p;
    endtask

    task automatic go_idle(input int rc, input int dwell);
        push(0, rc, 1'b0, dwell);
        drive(1'b0, 1'b0, 1'b0);
        cyc(6);
    endtask

    // Monitor: samples on every falling clock edge, and 1 ns after an async reset
    initial begin : monitor
        snap_t cur, prev;
        exp_t  e;
        int    dw;
        int    idx;
        bit    first;
        first = 1'b1;
        dw    = 0;
        idx   = 0;
        prev  = '0;
        wait (rst_div_n === 1'b1);
        forever begin
            @(negedge clk_div or negedge rst_div_n);
            if (!rst_div_n) #1;
            cur = {bus.state, bus.pll_rst, bus.pll_gate, bus.phy_ready,
                   bus.lock_lost, bus.fail, bus.retry_cnt};
            if (first || cur.st != prev.st) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_transition t=%0t got state=%0d", $time, cur.st);
                end else begin
                    e = q.pop_front();
                    n_vec++;
                    if (cur !== e.s) begin
                        n_err++;
                        $display("FAIL entry[%0d] t=%0t got st=%0d rst=%b gate=%b rdy=%b ll=%b fail=%b rc=%0d, need st=%0d rst=%b gate=%b rdy=%b ll=%b fail=%b rc=%0d",
                                 idx, $time, cur.st, cur.rst, cur.gate, cur.rdy, cur.ll, cur.fl, cur.rc,
                                 e.s.st, e.s.rst, e.s.gate, e.s.rdy, e.s.ll, e.s.fl, e.s.rc);
                    end
                    if (!first && e.dwell != 0) begin
                        n_vec++;
                        if (dw != e.dwell) begin
                            n_err++;
                            $display("FAIL dwell[%0d] t=%0t state %0d lasted %0d cycles, need %0d",
                                     idx, $time, prev.st, dw, e.dwell);
                        end
                    end
                    idx++;
                end
                dw    = 1;
                first = 1'b0;
            end else begin
                dw++;
            end
            prev = cur;
        end
    end

    initial begin : stimulus
        drive(1'b0, 1'b0, 1'b0);
        rst_div_n = 1'b0;
        cyc(3);
        push(0, 0, 1'b0, 0);
        rst_div_n = 1'b1;
        cyc(4);

        // Nominal bring-up: pll_lock rises 5 cycles after pll_rst falls
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        push(4, 0, 1'b0, 8);
        push(5, 0, 1'b0, 8);
        push(6, 0, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0);
        cyc(12);
        bus.pll_lock = 1'b1;
        cyc(16);
        go_idle(0, 0);

        // Timeout with two retries, then sticky fail cleared by start=0
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        push(2, 1, 1'b0, 20);
        push(3, 1, 1'b0, 4);
        push(2, 2, 1'b0, 20);
        push(3, 2, 1'b0, 4);
        push(7, 2, 1'b0, 20);
        drive(1'b1, 1'b1, 1'b0);
        cyc(80);
        go_idle(2, 0);

        // One-cycle lock glitch at SETTLE count 5
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        push(4, 0, 1'b0, 1);
        push(3, 0, 1'b0, 6);
        push(4, 0, 1'b0, 1);
        push(5, 0, 1'b0, 8);
        push(6, 0, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b1);
        cyc(11);
        bus.pll_lock = 1'b0;
        cyc(1);
        bus.pll_lock = 1'b1;
        cyc(19);

        // Lock loss for 10 cycles while READY
`ifdef PLL_AUTO_RELOCK_EN
        push(2, 0, 1'b1, 0);
        push(3, 0, 1'b0, 4);
        push(4, 0, 1'b0, 6);
        push(5, 0, 1'b0, 8);
        push(6, 0, 1'b0, 2);
`else
        push(7, 0, 1'b1, 0);
`endif
        bus.pll_lock = 1'b0;
        cyc(10);
        bus.pll_lock = 1'b1;
        cyc(20);
        go_idle(0, 0);

        // MMCM loss during WAIT_LOCK, then full relock
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        push(1, 0, 1'b0, 5);
        push(2, 0, 1'b0, 5);
        push(3, 0, 1'b0, 4);
        push(4, 0, 1'b0, 1);
        push(5, 0, 1'b0, 8);
        push(6, 0, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0);
        cyc(9);
        bus.mmcm_lock = 1'b0;
        cyc(5);
        bus.mmcm_lock = 1'b1;
        bus.pll_lock  = 1'b1;
        cyc(25);
        go_idle(0, 0);

        // start=0 on the same edge as the lock timeout
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        drive(1'b1, 1'b1, 1'b0);
        cyc(26);
        go_idle(0, 20);

        // Asynchronous reset while in GATE
        push(1, 0, 1'b0, 0);
        push(2, 0, 1'b0, 2);
        push(3, 0, 1'b0, 4);
        push(4, 0, 1'b0, 1);
        push(5, 0, 1'b0, 8);
        push(0, 0, 1'b0, 1);
        drive(1'b1, 1'b1, 1'b1);
        cyc(16);
        #2;
        rst_div_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        cyc(3);
        rst_div_n = 1'b1;
        cyc(6);

        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending entries, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
